uart_rx: RTL and testbench

UART receiver peripheral for the HOKSTER auxiliary bus, the receive counterpart of `uart_tx`. It samples the asynchronous serial line (8N1, LSB first), reassembles bytes into a holding register and raises an interrupt on each complete byte. It exposes a data register and a status register at fixed bus addresses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, bus addresses and default bit timing
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam logic [15:0] TXDATA_ADDR = 16'h0110;
   localparam logic [15:0] TXSTAT_ADDR = 16'h0111;
   localparam logic [15:0] RXDATA_ADDR = 16'h0112;
   localparam logic [15:0] RXSTAT_ADDR = 16'h0113;

   // 100 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchronizer for an asynchronous single-bit input
module uart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   // STAGES must be at least 2
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with data/status registers on the auxiliary bus
module uart_rx #(
   parameter int          CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
   parameter logic [15:0] RXDATA_ADDR  = uart_pkg::RXDATA_ADDR,
   parameter logic [15:0] RXSTAT_ADDR  = uart_pkg::RXSTAT_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        rxin,
   input  logic        ack,
   output logic        irq,
   output logic [7:0]  rxdata_out,
   output logic        baudpulse,
   output logic [1:0]  state,
   output logic [7:0]  rxsr_out,
   output logic [3:0]  rxctr_out
);
   import uart_pkg::*;

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   rx_state_t     state_q, state_d;
   logic          rx_s, rx_prev;
   logic [CW-1:0] baud_cnt;
   logic [7:0]    rxsr, rxdata;
   logic [3:0]    rxctr;
   logic          rxfull, overrun, frame_err;
   logic          fall, expire, load_half, load_full, shift_en, clr_ctr, stop_ok, stop_bad;
   logic          rd_data, rd_stat;

   uart_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync (
      .clk    (clk),
      .resetn (rst),
      .d      (rxin),
      .q      (rx_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_prev <= 1'b1;
      else      rx_prev <= rx_s;
   end

   assign fall    = rx_prev & ~rx_s;
   assign expire  = (state_q != ST_IDLE) && (baud_cnt == '0);
   assign rd_data = (addr == RXDATA_ADDR);
   assign rd_stat = (addr == RXSTAT_ADDR);

   always_comb begin
      state_d   = state_q;
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      clr_ctr   = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d   = ST_START;
               load_half = 1'b1;
            end
         end
         ST_START: begin
            if (expire) begin
               // a start bit that is high again at mid-bit was only a glitch
               if (!rx_s) begin
                  state_d   = ST_DATA;
                  load_full = 1'b1;
                  clr_ctr   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (expire) begin
               shift_en  = 1'b1;
               load_full = 1'b1;
               if (rxctr == 4'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (expire) begin
               state_d  = ST_IDLE;
               stop_ok  = rx_s;
               stop_bad = ~rx_s;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         baud_cnt <= '0;
         rxsr     <= 8'h00;
         rxctr    <= 4'd0;
      end else begin
         state_q <= state_d;
         if (load_half)                               baud_cnt <= HALF_LOAD;
         else if (load_full)                          baud_cnt <= FULL_LOAD;
         else if (state_q != ST_IDLE && !expire)      baud_cnt <= baud_cnt - 1'b1;
         if (shift_en) rxsr <= {rx_s, rxsr[7:1]};
         if (clr_ctr)       rxctr <= 4'd0;
         else if (shift_en) rxctr <= rxctr + 4'd1;
      end
   end

   // hardware sets take priority over read/ack clears
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxdata     <= 8'h00;
         rxfull     <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         irq        <= 1'b0;
         rxdata_out <= 8'h00;
      end else begin
         if (stop_ok) rxdata <= rxsr;

         if (stop_ok)      rxfull <= 1'b1;
         else if (rd_data) rxfull <= 1'b0;

         if (stop_ok && rxfull) overrun <= 1'b1;
         else if (rd_stat)      overrun <= 1'b0;

         if (stop_bad)     frame_err <= 1'b1;
         else if (rd_stat) frame_err <= 1'b0;

         if (stop_ok)  irq <= 1'b1;
         else if (ack) irq <= 1'b0;

         if (rd_data)      rxdata_out <= rxdata;
         else if (rd_stat) rxdata_out <= {5'b0, frame_err, overrun, rxfull};
         else              rxdata_out <= 8'h00;
      end
   end

   assign baudpulse = expire;
   assign state     = state_q;
   assign rxsr_out  = rxsr;
   assign rxctr_out = rxctr;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a register-level reference model
module tb_uart_rx;

   localparam int          CPB     = 16;
   localparam logic [15:0] A_DATA  = 16'h0112;
   localparam logic [15:0] A_STAT  = 16'h0113;
   localparam logic [15:0] A_OTHER = 16'h0110;
   localparam int          IRQ_LAT = 2 + CPB / 2 + 9 * CPB + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        rxin = 1'b1;
   logic        ack = 1'b0;
   logic        irq;
   logic [7:0]  rxdata_out;
   logic        baudpulse;
   logic [1:0]  state;
   logic [7:0]  rxsr_out;
   logic [3:0]  rxctr_out;

   uart_rx #(.CLKS_PER_BIT(CPB), .RXDATA_ADDR(A_DATA), .RXSTAT_ADDR(A_STAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .rxin       (rxin),
      .ack        (ack),
      .irq        (irq),
      .rxdata_out (rxdata_out),
      .baudpulse  (baudpulse),
      .state      (state),
      .rxsr_out   (rxsr_out),
      .rxctr_out  (rxctr_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int bp_total = 0;
   int irq_rise_cyc = -1;
   logic irq_last = 1'b0;
   int start_cyc = 0;
   int bp_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (baudpulse) bp_total = bp_total + 1;
      if (irq && !irq_last) irq_rise_cyc = cyc;
      irq_last = irq;
   end

   // reference model: programmer-visible receiver state
   logic [7:0] m_data = 8'h00;
   logic       m_full = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_irq = 1'b0;

   function automatic logic [7:0] exp_read(input logic [15:0] a);
      if (a == A_DATA) return m_data;
      if (a == A_STAT) return {5'b0, m_ferr, m_ovr, m_full};
      return 8'h00;
   endfunction

   function automatic void model_read(input logic [15:0] a);
      if (a == A_DATA) m_full = 1'b0;
      if (a == A_STAT) begin
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end
   endfunction

   function automatic void model_reset();
      m_data = 8'h00; m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_irq = 1'b0;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rxin = 1'b0;
      start_cyc = cyc;
      bp_start = bp_total;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxin = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxin = stop;
      repeat (CPB) @(negedge clk);
      rxin = 1'b1;
      repeat (CPB) @(negedge clk);
      if (stop) begin
         m_ovr  = m_ovr | m_full;
         m_full = 1'b1;
         m_data = b;
         m_irq  = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
      @(negedge clk);
      addr = a;
      @(negedge clk);
      v = rxdata_out;
      addr = 16'h0000;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      m_irq = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (rxdata_out !== 8'h00) begin failures++; $display("FAIL reset_rxdata_out got=%h exp=00", rxdata_out); end
      checks++; if (baudpulse !== 1'b0) begin failures++; $display("FAIL reset_baudpulse got=%b exp=0", baudpulse); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (rxsr_out !== 8'h00) begin failures++; $display("FAIL reset_rxsr got=%h exp=00", rxsr_out); end
      checks++; if (rxctr_out !== 4'd0) begin failures++; $display("FAIL reset_rxctr got=%0d exp=0", rxctr_out); end
      model_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] v;
      send_frame(8'hA9, 1'b1);
      checks++; if (irq_rise_cyc - start_cyc != IRQ_LAT) begin failures++; $display("FAIL basic_irq_latency got=%0d exp=%0d", irq_rise_cyc - start_cyc, IRQ_LAT); end
      checks++; if (bp_total - bp_start != 10) begin failures++; $display("FAIL basic_baudpulses got=%0d exp=10", bp_total - bp_start); end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL basic_irq got=%b exp=%b", irq, m_irq); end
      checks++; if (rxsr_out !== 8'hA9) begin failures++; $display("FAIL basic_rxsr got=%h exp=a9", rxsr_out); end
      checks++; if (rxctr_out !== 4'd8) begin failures++; $display("FAIL basic_rxctr got=%0d exp=8", rxctr_out); end
      bus_read(A_STAT, v);
      checks++; if (v !== 8'h01 || v !== exp_read(A_STAT)) begin failures++; $display("FAIL basic_status got=%h exp=01", v); end
      model_read(A_STAT);
      bus_read(A_DATA, v);
      checks++; if (v !== exp_read(A_DATA)) begin failures++; $display("FAIL basic_data got=%h exp=%h", v, exp_read(A_DATA)); end
      model_read(A_DATA);
      bus_read(A_OTHER, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL basic_other_addr got=%h exp=00", v); end
      pulse_ack();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL basic_ack_irq got=%b exp=0", irq); end
      bus_read(A_STAT, v);
      checks++; if (v !== exp_read(A_STAT)) begin failures++; $display("FAIL basic_status_after got=%h exp=%h", v, exp_read(A_STAT)); end
      model_read(A_STAT);
   endtask

   task automatic test_glitch();
      logic [7:0] v;
      @(negedge clk);
      rxin = 1'b0;
      repeat (3) @(negedge clk);
      rxin = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_start_state got=%0d exp=1", state); end
      repeat (9) @(negedge clk);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL glitch_back_idle got=%0d exp=0", state); end
      repeat (2 * CPB) @(negedge clk);
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL glitch_irq got=%b exp=%b", irq, m_irq); end
      bus_read(A_STAT, v);
      checks++; if (v !== exp_read(A_STAT)) begin failures++; $display("FAIL glitch_status got=%h exp=%h", v, exp_read(A_STAT)); end
      model_read(A_STAT);
   endtask

   task automatic test_frame_err();
      logic [7:0] v;
      send_frame(8'h27, 1'b0);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ferr_irq got=%b exp=0", irq); end
      bus_read(A_STAT, v);
      checks++; if (v !== 8'h04 || v !== exp_read(A_STAT)) begin failures++; $display("FAIL ferr_status got=%h exp=04", v); end
      model_read(A_STAT);
      bus_read(A_STAT, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL ferr_status_cleared got=%h exp=00", v); end
      model_read(A_STAT);
   endtask

   task automatic test_overrun();
      logic [7:0] v;
      send_frame(8'h27, 1'b1);
      send_frame(8'h53, 1'b1);
      bus_read(A_STAT, v);
      checks++; if (v !== 8'h03 || v !== exp_read(A_STAT)) begin failures++; $display("FAIL ovr_status got=%h exp=03", v); end
      model_read(A_STAT);
      bus_read(A_DATA, v);
      checks++; if (v !== 8'h53) begin failures++; $display("FAIL ovr_data got=%h exp=53", v); end
      model_read(A_DATA);
      pulse_ack();
   endtask

   task automatic test_ack_collision();
      logic [7:0] v;
      fork
         send_frame(8'h3C, 1'b1);
         begin
            repeat (IRQ_LAT) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
         end
      join
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ack_collision_irq got=%b exp=1", irq); end
      bus_read(A_DATA, v);
      checks++; if (v !== exp_read(A_DATA)) begin failures++; $display("FAIL ack_collision_data got=%h exp=%h", v, exp_read(A_DATA)); end
      model_read(A_DATA);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] v;
      logic [7:0] b;
      b = 8'hC6;
      @(negedge clk);
      rxin = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxin = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxin = b[4];
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b0;
      rxin = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", irq); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
      checks++; if (rxsr_out !== 8'h00 || rxctr_out !== 4'd0) begin failures++; $display("FAIL midrst_shift got=%h/%0d exp=00/0", rxsr_out, rxctr_out); end
      checks++; if (rxdata_out !== 8'h00 || baudpulse !== 1'b0) begin failures++; $display("FAIL midrst_bus got=%h/%b exp=00/0", rxdata_out, baudpulse); end
      rst = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrst_stays_idle got=%0d exp=0", state); end
      send_frame(8'h5A, 1'b1);
      checks++; if (irq_rise_cyc - start_cyc != IRQ_LAT) begin failures++; $display("FAIL midrst_irq_latency got=%0d exp=%0d", irq_rise_cyc - start_cyc, IRQ_LAT); end
      bus_read(A_STAT, v);
      checks++; if (v !== exp_read(A_STAT)) begin failures++; $display("FAIL midrst_status got=%h exp=%h", v, exp_read(A_STAT)); end
      model_read(A_STAT);
      bus_read(A_DATA, v);
      checks++; if (v !== 8'h5A) begin failures++; $display("FAIL midrst_data got=%h exp=5a", v); end
      model_read(A_DATA);
      pulse_ack();
   endtask

   task automatic test_random();
      logic [7:0] v;
      logic [7:0] b;
      logic       stop;
      logic [15:0] a;
      for (int n = 0; n < 8; n++) begin
         b = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_frame(b, stop);
         checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq[%0d] got=%b exp=%b", n, irq, m_irq); end
         checks++; if (rxsr_out !== b) begin failures++; $display("FAIL rand_rxsr[%0d] got=%h exp=%h", n, rxsr_out, b); end
         checks++; if (bp_total - bp_start != 10) begin failures++; $display("FAIL rand_baudpulses[%0d] got=%0d exp=10", n, bp_total - bp_start); end
         case ($urandom_range(0, 3))
            0: a = A_STAT;
            1: a = A_DATA;
            2: a = A_OTHER;
            default: a = 16'hFFFF;
         endcase
         if (a != 16'hFFFF) begin
            bus_read(a, v);
            checks++; if (v !== exp_read(a)) begin failures++; $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", n, a, v, exp_read(a)); end
            model_read(a);
         end
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_ack[%0d] got=%b exp=%b", n, irq, m_irq); end
         end
      end
      bus_read(A_STAT, v);
      checks++; if (v !== exp_read(A_STAT)) begin failures++; $display("FAIL rand_final_status got=%h exp=%h", v, exp_read(A_STAT)); end
      model_read(A_STAT);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_ack_collision();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
